// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared constants, FSM encoding and parity helper for the PS/2 key event receiver
package ps2_pkg;

  localparam logic [7:0] PS2_EXTENDED = 8'hE0;
  localparam logic [7:0] PS2_RELEASED = 8'hF0;
  localparam logic [7:0] PS2_BAT_OK   = 8'hAA;
  localparam logic [7:0] PS2_BAT_ERR  = 8'hFC;

  localparam int EVT_W = 10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DATA   = 3'd1,
    ST_PARITY = 3'd2,
    ST_STOP   = 3'd3,
    ST_CHECK  = 3'd4
  } rx_state_e;

  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// rtl/ps2_evt_fifo.sv - first-word fall-through event FIFO with valid/ready pop and overflow pulse
module ps2_evt_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [WIDTH-1:0]         o_data,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             r_overflow;
  logic             w_valid;
  logic             w_pop;
  logic             w_wr;

  assign w_valid = (r_level != '0);
  assign w_pop   = w_valid & i_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign w_wr    = i_push & ((r_level != LVL_FULL) | w_pop);

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_push_data;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= i_push & ~w_wr;
      if (w_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_valid    = w_valid;
  assign o_data     = w_valid ? r_mem[r_rd_ptr] : '0;
  assign o_level    = r_level;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/ps2_key_event_rx.sv
// rtl/ps2_key_event_rx.sv - PS/2 clock filter, 11-bit deframer and E0/F0 prefix folding into key events
module ps2_key_event_rx
  import ps2_pkg::*;
#(
  parameter int FILT_LEN    = 8,
  parameter int TIMEOUT_CYC = 4000,
  parameter int FIFO_DEPTH  = 8,
  parameter bit PASS_PREFIX = 1'b0
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_ps2_clk,
  input  logic                          i_ps2_data,
  output logic                          o_evt_valid,
  input  logic                          i_evt_ready,
  output logic [7:0]                    o_evt_code,
  output logic                          o_evt_ext,
  output logic                          o_evt_brk,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
  output logic                          o_parity_err,
  output logic                          o_frame_err,
  output logic                          o_overflow
);

  localparam int FW = (FILT_LEN > 2) ? $clog2(FILT_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]       r_clk_sync;
  logic [1:0]       r_dat_sync;
  logic             r_filt_clk;
  logic [FW-1:0]    r_filt_cnt;
  logic             r_strobe;

  rx_state_e        r_state;
  logic [7:0]       r_shift;
  logic [2:0]       r_bit_cnt;
  logic             r_par_bit;
  logic             r_stop_bit;
  logic [TW-1:0]    r_to_cnt;
  logic             r_ext_f;
  logic             r_brk_f;
  logic             r_push;
  logic [EVT_W-1:0] r_push_data;
  logic             r_parity_err;
  logic             r_frame_err;

  logic             w_timeout;
  logic             w_bit;
  logic [EVT_W-1:0] w_head;

  // The filtered clock flips only after FILT_LEN consecutive samples disagreeing with it
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_clk_sync <= 2'b11;
      r_dat_sync <= 2'b11;
      r_filt_clk <= 1'b1;
      r_filt_cnt <= '0;
      r_strobe   <= 1'b0;
    end else begin
      r_clk_sync <= {r_clk_sync[0], i_ps2_clk};
      r_dat_sync <= {r_dat_sync[0], i_ps2_data};
      r_strobe   <= 1'b0;
      if (r_clk_sync[1] == r_filt_clk) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == FW'(FILT_LEN - 1)) begin
        r_filt_clk <= r_clk_sync[1];
        r_filt_cnt <= '0;
        r_strobe   <= r_filt_clk;
      end else begin
        r_filt_cnt <= r_filt_cnt + FW'(1);
      end
    end
  end

  assign w_bit     = r_dat_sync[1];
  assign w_timeout = (r_to_cnt == TW'(TIMEOUT_CYC)) &&
                     (r_state inside {ST_DATA, ST_PARITY, ST_STOP});

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_par_bit    <= 1'b0;
      r_stop_bit   <= 1'b0;
      r_to_cnt     <= '0;
      r_ext_f      <= 1'b0;
      r_brk_f      <= 1'b0;
      r_push       <= 1'b0;
      r_push_data  <= '0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_push       <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      if (r_state == ST_IDLE || r_strobe) r_to_cnt <= '0;
      else                                r_to_cnt <= r_to_cnt + TW'(1);

      if (w_timeout) begin
        r_state     <= ST_IDLE;
        r_frame_err <= 1'b1;
        r_ext_f     <= 1'b0;
        r_brk_f     <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (r_strobe && !w_bit) begin
              r_state   <= ST_DATA;
              r_bit_cnt <= '0;
            end
          end
          ST_DATA: begin
            if (r_strobe) begin
              r_shift   <= {w_bit, r_shift[7:1]};
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) r_state <= ST_PARITY;
            end
          end
          ST_PARITY: begin
            if (r_strobe) begin
              r_par_bit <= w_bit;
              r_state   <= ST_STOP;
            end
          end
          ST_STOP: begin
            if (r_strobe) begin
              r_stop_bit <= w_bit;
              r_state    <= ST_CHECK;
            end
          end
          ST_CHECK: begin
            r_state <= ST_IDLE;
            if (!r_stop_bit) begin
              r_frame_err <= 1'b1;
              r_ext_f     <= 1'b0;
              r_brk_f     <= 1'b0;
            end else if (!odd_parity_ok(r_shift, r_par_bit)) begin
              r_parity_err <= 1'b1;
              r_ext_f      <= 1'b0;
              r_brk_f      <= 1'b0;
            end else if (r_shift == PS2_EXTENDED || r_shift == PS2_RELEASED) begin
              if (r_shift == PS2_EXTENDED) r_ext_f <= 1'b1;
              else                         r_brk_f <= 1'b1;
              if (PASS_PREFIX) begin
                r_push      <= 1'b1;
                r_push_data <= {r_shift, 2'b00};
              end
            end else begin
              r_push      <= 1'b1;
              r_push_data <= {r_shift, r_ext_f, r_brk_f};
              r_ext_f     <= 1'b0;
              r_brk_f     <= 1'b0;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  ps2_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EVT_W)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_push      (r_push),
    .i_push_data (r_push_data),
    .o_valid     (o_evt_valid),
    .i_ready     (i_evt_ready),
    .o_data      (w_head),
    .o_level     (o_fifo_level),
    .o_overflow  (o_overflow)
  );

  assign o_evt_code   = w_head[9:2];
  assign o_evt_ext    = w_head[1];
  assign o_evt_brk    = w_head[0];
  assign o_parity_err = r_parity_err;
  assign o_frame_err  = r_frame_err;

endmodule
